// File: rtl/uart_rx_param.sv
// Purpose: parametrised UART receiver with a 2-flop synchroniser, oversampled bit timing and a one-entry valid/ready output buffer. Optional 2-of-3 majority sampling is enabled by UART_RX_MAJORITY_EN.
// Latency: rx_valid rises 2 clk after the final stop-bit sample point, plus 1 tick when UART_RX_MAJORITY_EN is defined.
// Backpressure: if the buffer is still full when a character completes, the new character is dropped and overrun_err is set; overrun_err stays set until err_clr.
module uart_rx_param #(
    parameter int CLK_FREQ   = 24000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    input  logic                 err_clr
);

    localparam int DIV   = (CLK_FREQ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SUB_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, DONE} state_t;

    state_t state, state_nxt;

    logic                 rx_meta, rxs, rxs_prev;
    logic [DIV_W-1:0]     div_cnt;
    logic [SUB_W-1:0]     sub_cnt;
    logic                 tick;
    logic                 samp_evt;
    logic                 bit_val;
    logic [DATA_BITS-1:0] shreg;
    logic [BIT_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic                 par_pend, frm_pend, brk_wait, par_err_q;
    logic                 par_exp;

    // strobes decoded from the FSM
    logic start_det, start_ok, shift_en, par_chk, stop_en, buf_ld, ovr_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= rx;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    // Restarting both counters on the start edge puts every sample point at a fixed offset from it.
    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            sub_cnt <= '0;
        end else if (start_det) begin
            div_cnt <= '0;
            sub_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            sub_cnt <= (sub_cnt == SUB_LAST) ? '0 : sub_cnt + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    localparam logic [SUB_W-1:0] SUB_V0 = SUB_W'(OVERSAMPLE/2 - 2);
    localparam logic [SUB_W-1:0] SUB_V1 = SUB_W'(OVERSAMPLE/2 - 1);
    localparam logic [SUB_W-1:0] SUB_V2 = SUB_W'(OVERSAMPLE/2);

    logic vote_a, vote_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote_a <= 1'b1;
            vote_b <= 1'b1;
        end else begin
            if (tick && sub_cnt == SUB_V0) vote_a <= rxs;
            if (tick && sub_cnt == SUB_V1) vote_b <= rxs;
        end
    end

    // The third vote is the live sample, so the decision lands one tick later.
    assign samp_evt = tick && (sub_cnt == SUB_V2);
    assign bit_val  = (vote_a & vote_b) | (vote_a & rxs) | (vote_b & rxs);
`else
    localparam logic [SUB_W-1:0] SUB_V1 = SUB_W'(OVERSAMPLE/2 - 1);

    assign samp_evt = tick && (sub_cnt == SUB_V1);
    assign bit_val  = rxs;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_det) state_nxt = START;
            START: if (samp_evt)  state_nxt = bit_val ? IDLE : DATA;
            DATA:  if (samp_evt && bit_idx == LAST_BIT)
                       state_nxt = (PARITY != 0) ? PAR : STOP;
            PAR:   if (samp_evt) state_nxt = STOP;
            STOP:  if (samp_evt && stop_idx == LAST_STOP) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_det = 1'b0;
        start_ok  = 1'b0;
        shift_en  = 1'b0;
        par_chk   = 1'b0;
        stop_en   = 1'b0;
        buf_ld    = 1'b0;
        ovr_set   = 1'b0;
        case (state)
            IDLE:  start_det = !brk_wait && rxs_prev && !rxs;
            START: start_ok  = samp_evt && !bit_val;
            DATA:  shift_en  = samp_evt;
            PAR:   par_chk   = samp_evt;
            STOP:  stop_en   = samp_evt;
            DONE: begin
                buf_ld  = !rx_valid || rx_ready;
                ovr_set = rx_valid && !rx_ready;
            end
            default: ;
        endcase
    end

    assign par_exp = (PARITY == 1) ? ~(^shreg) : ^shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_pend <= 1'b0;
            frm_pend <= 1'b0;
            brk_wait <= 1'b0;
        end else begin
            if (start_ok) begin
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                par_pend <= 1'b0;
                frm_pend <= 1'b0;
            end
            if (shift_en) begin
                shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
                bit_idx <= bit_idx + 1'b1;
            end
            if (par_chk)
                par_pend <= (bit_val != par_exp);
            if (stop_en) begin
                stop_idx <= stop_idx + 1'b1;
                if (stop_idx == 1'b0)
                    frm_pend <= !bit_val;
            end
            // A low first stop bit may be a break: wait for the line to go high before re-arming.
            if (stop_en && stop_idx == 1'b0 && !bit_val)
                brk_wait <= 1'b1;
            else if (state == IDLE && rxs)
                brk_wait <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            par_err_q   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (buf_ld) begin
                rx_data   <= shreg;
                frame_err <= frm_pend;
                par_err_q <= par_pend;
                rx_valid  <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (ovr_set)      overrun_err <= 1'b1;
            else if (err_clr) overrun_err <= 1'b0;
        end
    end

    assign parity_err = (PARITY != 0) ? par_err_q : 1'b0;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance and an even-parity, 2-stop-bit instance, with scoreboards on each output handshake.
`timescale 1ns/1ps
module tb_uart_rx_param;

    // 24 MHz / 115200 baud is 208.33 clocks per bit; 208 stays well inside the sampling margin.
    localparam int BITC = 208;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_a, rx_b, rdy_a, rdy_b, clr_a, clr_b;
    logic [7:0] data_a, data_b;
    logic       vld_a, vld_b, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   tests = 0;
    int   fails = 0;

    always #20.833 clk = ~clk;

    uart_rx_param u_dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_data(data_a), .rx_valid(vld_a),
        .rx_ready(rdy_a), .frame_err(fe_a), .parity_err(pe_a), .overrun_err(ov_a),
        .err_clr(clr_a)
    );

    uart_rx_param #(.PARITY(2), .STOP_BITS(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .rx_data(data_b), .rx_valid(vld_b),
        .rx_ready(rdy_b), .frame_err(fe_b), .parity_err(pe_b), .overrun_err(ov_b),
        .err_clr(clr_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboards: pop one expected character per accepted transfer.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && vld_a && rdy_a) begin
            tests++;
            assert (q_a.size() != 0) else begin
                fails++;
                $error("FAIL a_unexpected_char: observed data 0x%0h expected no character", data_a);
            end
            if (q_a.size() != 0) begin
                exp_t e;
                e = q_a.pop_front();
                check("a_char", {22'd0, data_a, fe_a, pe_a}, {22'd0, e.d, e.fe, e.pe});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && vld_b && rdy_b) begin
            tests++;
            assert (q_b.size() != 0) else begin
                fails++;
                $error("FAIL b_unexpected_char: observed data 0x%0h expected no character", data_b);
            end
            if (q_b.size() != 0) begin
                exp_t e;
                e = q_b.pop_front();
                check("b_char", {22'd0, data_b, fe_b, pe_b}, {22'd0, e.d, e.fe, e.pe});
            end
        end
    end

    task automatic drive_bit(input bit sel_b, input logic v);
        if (sel_b) rx_b = v;
        else       rx_a = v;
        repeat (BITC) @(negedge clk);
    endtask

    task automatic send(input bit sel_b, input logic [7:0] d, input bit use_par,
                        input logic par, input logic stop, input int nstop);
        drive_bit(sel_b, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel_b, d[i]);
        if (use_par) drive_bit(sel_b, par);
        drive_bit(sel_b, stop);
        for (int i = 1; i < nstop; i++) drive_bit(sel_b, 1'b1);
        drive_bit(sel_b, 1'b1);
        drive_bit(sel_b, 1'b1);
    endtask

    initial begin
        logic [7:0] d;
        rst_n = 1'b0;
        rx_a = 1'b1; rx_b = 1'b1;
        rdy_a = 1'b1; rdy_b = 1'b1;
        clr_a = 1'b0; clr_b = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_a_data", data_a, 0);
        check("rst_a_vld",  vld_a, 0);
        check("rst_a_fe",   fe_a, 0);
        check("rst_a_pe",   pe_a, 0);
        check("rst_a_ov",   ov_a, 0);
        check("rst_b_data", data_b, 0);
        check("rst_b_vld",  vld_b, 0);
        check("rst_b_ov",   ov_b, 0);

        rst_n = 1'b1;
        repeat (BITC) @(negedge clk);

        // Defaults: two clean 8N1 characters
        q_a.push_back('{d: 8'h55, fe: 1'b0, pe: 1'b0});
        send(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 1);
        q_a.push_back('{d: 8'hAA, fe: 1'b0, pe: 1'b0});
        send(1'b0, 8'hAA, 1'b0, 1'b0, 1'b1, 1);
        check("t1_ov", ov_a, 0);

        // Even parity: wrong parity bit, then correct parity bit
        q_b.push_back('{d: 8'h03, fe: 1'b0, pe: 1'b1});
        send(1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 2);
        q_b.push_back('{d: 8'h07, fe: 1'b0, pe: 1'b0});
        send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 2);

        // Low stop bit gives one character with frame_err, then a clean one
        q_a.push_back('{d: 8'h41, fe: 1'b1, pe: 1'b0});
        send(1'b0, 8'h41, 1'b0, 1'b0, 1'b0, 1);
        repeat (BITC * 2) @(negedge clk);
        q_a.push_back('{d: 8'h42, fe: 1'b0, pe: 1'b0});
        send(1'b0, 8'h42, 1'b0, 1'b0, 1'b1, 1);

        // Overrun: consumer stalled across two characters
        rdy_a = 1'b0;
        q_a.push_back('{d: 8'h11, fe: 1'b0, pe: 1'b0});
        send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1);
        check("t4_vld_held", vld_a, 1);
        check("t4_data_held", data_a, 8'h11);
        check("t4_ov_before", ov_a, 0);
        send(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 1);
        check("t4_ov_set", ov_a, 1);
        check("t4_data_kept", data_a, 8'h11);
        check("t4_vld_kept", vld_a, 1);
        rdy_a = 1'b1;
        repeat (3) @(negedge clk);
        check("t4_vld_drained", vld_a, 0);
        check("t4_ov_sticky", ov_a, 1);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        @(negedge clk);
        check("t4_ov_cleared", ov_a, 0);

        // 2 us low glitch on an idle line must be rejected
        rx_a = 1'b0;
        repeat (48) @(negedge clk);
        rx_a = 1'b1;
        repeat (BITC * 2) @(negedge clk);
        check("t5_no_vld", vld_a, 0);
        q_a.push_back('{d: 8'h3C, fe: 1'b0, pe: 1'b0});
        send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1);

`ifdef UART_RX_MAJORITY_EN
        // Short glitch at mid-bit of data bit 4 is outvoted
        d = 8'hF0;
        q_a.push_back('{d: 8'hF0, fe: 1'b0, pe: 1'b0});
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, d[i]);
        rx_a = 1'b1;
        repeat (BITC/2 - 2) @(negedge clk);
        rx_a = 1'b0;
        repeat (3) @(negedge clk);
        rx_a = 1'b1;
        repeat (BITC - BITC/2 - 1) @(negedge clk);
        for (int i = 5; i < 8; i++) drive_bit(1'b0, d[i]);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
`endif

        // Reset during bit 4 of 0x5A aborts it; 0xC3 afterwards is clean
        d = 8'h5A;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, d[i]);
        rx_a = d[4];
        repeat (BITC/2) @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_vld_in_rst", vld_a, 0);
        rx_a = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (BITC * 12) @(negedge clk);
        check("t6_no_vld_after", vld_a, 0);
        q_a.push_back('{d: 8'hC3, fe: 1'b0, pe: 1'b0});
        send(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, 1);

        repeat (BITC) @(negedge clk);
        check("end_q_a_empty", q_a.size(), 0);
        check("end_q_b_empty", q_b.size(), 0);
        check("end_ov_a", ov_a, 0);
        check("end_ov_b", ov_b, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
